// File: rtl/sift_node_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sift_node_delay
//  Description : One heap-level sift-down stage. Reads the child pair at the
//                request position from a registered-output child store,
//                compares the sifted value against the smaller child and
//                either returns it unchanged or swaps it down. A swap writes
//                the value into the child slot and forwards it to the next
//                level.
//  Revision    : 1.0 - initial release
// ============================================================================
module sift_node_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // sift-down request
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  in_ready,
    // child level store
    output logic [DATA_WIDTH-1:0] nl_din,
    output logic [ADDR_WIDTH-1:0] nl_addr,
    output logic                  nl_we,
    output logic                  nl_branch,
    input  logic [DATA_WIDTH-1:0] nl_dout,
    // write-back for the request position
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [ADDR_WIDTH-1:0] res_addr,
    // continuation toward the next level
    output logic                  fwd_valid,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [ADDR_WIDTH:0]   fwd_addr,
    input  logic                  fwd_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAPL = 3'd2,
        S_CAPR = 3'd3,
        S_DEC  = 3'd4,
        S_FWD  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_v;     // value being sifted
    logic [DATA_WIDTH-1:0] r_l;     // left child
    logic [DATA_WIDTH-1:0] r_r;     // right child
    logic [ADDR_WIDTH-1:0] r_a;     // request position / child-pair address
    logic                  r_sel;   // branch chosen on the last swap

    logic                  w_swap;
    logic                  w_sel;

    // LEVEL is carried for integration bookkeeping only; it selects no logic.
    if (LEVEL >= 0) begin : g_level_nonneg
    end else begin : g_level_neg
    end

    // Smaller child wins, ties go left. An all-ones (empty) child is only the
    // minimum when both are empty, and then no value can exceed it, so empty
    // slots never attract a swap.
    assign w_sel  = (r_l <= r_r) ? 1'b0 : 1'b1;
    assign w_swap = (r_v > r_l) || (r_v > r_r);

    // State register and datapath captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_v     <= '0;
            r_l     <= '0;
            r_r     <= '0;
            r_a     <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_v <= in_data;
                        r_a <= in_addr;
                    end
                end
                S_CAPL:  r_l <= nl_dout;
                S_CAPR:  r_r <= nl_dout;
                S_DEC: begin
                    if (w_swap) begin
                        r_sel <= w_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode; reset forces the idle-looking outputs
    // immediately so a pending forward or write is dropped in the reset cycle.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        nl_din       = '0;
        nl_addr      = '0;
        nl_we        = 1'b0;
        nl_branch    = 1'b0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_addr     = '0;
        fwd_valid    = 1'b0;
        fwd_data     = '0;
        fwd_addr     = '0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RD;
                end
            end
            S_RD: begin
                nl_addr      = r_a;
                w_state_next = S_CAPL;
            end
            S_CAPL: begin
                nl_addr      = r_a;
                w_state_next = S_CAPR;
            end
            S_CAPR: begin
                nl_addr      = r_a;
                nl_branch    = 1'b1;
                w_state_next = S_DEC;
            end
            S_DEC: begin
                res_valid = 1'b1;
                res_addr  = r_a;
                if (w_swap) begin
                    res_data     = w_sel ? r_r : r_l;
                    nl_we        = 1'b1;
                    nl_din       = r_v;
                    nl_addr      = r_a;
                    nl_branch    = w_sel;
                    w_state_next = S_FWD;
                end else begin
                    res_data     = r_v;
                    w_state_next = S_IDLE;
                end
            end
            S_FWD: begin
                fwd_valid = 1'b1;
                fwd_data  = r_v;
                fwd_addr  = {r_a, r_sel};
                if (fwd_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (rst) begin
            w_state_next = S_IDLE;
            in_ready     = 1'b1;
            nl_din       = '0;
            nl_addr      = '0;
            nl_we        = 1'b0;
            nl_branch    = 1'b0;
            res_valid    = 1'b0;
            res_data     = '0;
            res_addr     = '0;
            fwd_valid    = 1'b0;
            fwd_data     = '0;
            fwd_addr     = '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/sift_node_delay.md
SIFT_NODE_DELAY -- requirements
Module: sift_node_delay

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width; unsigned key.
REQ-002 Parameter ADDR_WIDTH, default 5: node index width within the child level store.
REQ-003 Parameter LEVEL, default 1: heap level of the child store; passed through for integration only, no functional effect.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  sift-down request present.
REQ-007 in_data  input  DATA_WIDTH  value being sifted down.
REQ-008 in_addr  input  ADDR_WIDTH  index of this value's position; equals the child-pair address in the child store.
REQ-009 in_ready  output  1  request accepted when in_valid & in_ready at a rising edge.
REQ-010 nl_din  output  DATA_WIDTH  write data to the child store.
REQ-011 nl_addr  output  ADDR_WIDTH  child store address.
REQ-012 nl_we  output  1  child store write enable.
REQ-013 nl_branch  output  1  child select; 0 = left memory, 1 = right memory.
REQ-014 nl_dout  input  DATA_WIDTH  store read data: registered RAM output, 1-cycle latency, muxed by the current nl_branch.
REQ-015 res_valid  output  1  one-cycle pulse; write-back for position in_addr is available.
REQ-016 res_data  output  DATA_WIDTH  value to store at position in_addr.
REQ-017 res_addr  output  ADDR_WIDTH  latched in_addr.
REQ-018 fwd_valid  output  1  continuation request for the next level.
REQ-019 fwd_data  output  DATA_WIDTH  value continuing downward.
REQ-020 fwd_addr  output  ADDR_WIDTH+1  {latched in_addr, selected branch}.
REQ-021 fwd_ready  input  1  next level accepts when fwd_valid & fwd_ready.

Function
REQ-022 FSM states: IDLE, RD, CAPL, CAPR, DEC, FWD; in_ready = 1 only in IDLE.
REQ-023 IDLE: on accept, latch V=in_data and A=in_addr, then go to RD.
REQ-024 RD: drive nl_addr=A, nl_branch=0, nl_we=0, then go to CAPL.
REQ-025 CAPL: hold nl_addr=A, nl_branch=0, capture L=nl_dout, then go to CAPR.
REQ-026 CAPR: hold nl_addr=A, drive nl_branch=1, capture R=nl_dout (both RAMs were read at A in RD), then go to DEC.
REQ-027 DEC, no-swap case (V <= L and V <= R, unsigned): res_valid=1, res_data=V, res_addr=A, nl_we=0; next state IDLE.
REQ-028 DEC, swap case: sel=0 if L <= R, else sel=1 (tie goes left); C = selected child value.
REQ-029 DEC, swap case outputs: res_valid=1, res_data=C, res_addr=A; nl_we=1, nl_din=V, nl_addr=A, nl_branch=sel; next state FWD.
REQ-030 FWD: fwd_valid=1, fwd_data=V, fwd_addr={A,sel}, all held stable until fwd_ready; on handshake go to IDLE; nl_we=0.
REQ-031 Latency: accept at edge E0 gives RD in cycle 1, DEC (res_valid) in cycle 4, fwd_valid from cycle 5; minimum request spacing is 5 cycles without a swap and 6 with a swap and immediate fwd_ready.
REQ-032 nl_we is high in no state other than DEC, and only for one cycle per swap.
REQ-033 An all-ones child value acts as an empty slot; it is never selected unless V is all-ones too, in which case no swap occurs.
REQ-034 in_valid is ignored outside IDLE; there is no queuing.
REQ-035 fwd_ready asserted outside FWD has no effect.
REQ-036 Outputs not named as active in the current state are driven 0; nl_addr and nl_branch are 0 in IDLE.

Reset
REQ-037 rst at a rising edge forces IDLE from any state, including mid-read and FWD; a pending forward is discarded.
REQ-038 During rst, and in the cycle after it, in_ready=1 and res_valid=fwd_valid=nl_we=0.
REQ-039 rst clears V, L, R, A and sel to 0.

Verification
REQ-040 Store left[3]=10, right[3]=20; request V=5, A=3 -> res_valid in cycle 4 with res_data=5, res_addr=3; no nl_we; no fwd_valid.
REQ-041 Store left[3]=10, right[3]=7; request V=15, A=3 -> in DEC: nl_we=1, nl_branch=1, nl_addr=3, nl_din=15, res_data=7; then fwd_addr=7, fwd_data=15.
REQ-042 Tie left[2]=right[2]=9; request V=12, A=2 -> sel=0, res_data=9, fwd_addr=4.
REQ-043 Hold fwd_ready=0 for 3 cycles in FWD -> fwd_valid, fwd_data and fwd_addr stay stable; in_ready stays 0; a new in_valid is ignored until one cycle after the handshake.
REQ-044 Assert rst in CAPR, then in FWD -> next cycle IDLE with in_ready=1 and all valid/we outputs 0; a following request behaves exactly as in REQ-040.
REQ-045 Both children 0xFFFFFFFF with V=0xFFFFFFFF -> no swap; res_data=0xFFFFFFFF.
